// File: rtl/mmio_responder.sv
// Memory-mapped I/O target on the SRAM-style A1/CSB1/WEB1/OEB1 port: transmit byte FIFO,
// down-counting timer with interrupt, and a scratch register in a 16-word window.
module mmio_responder #(
  parameter logic [7:0] BASE       = 8'hF0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         N          = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   A1,
  input  logic         CSB1,
  input  logic         WEB1,
  input  logic         OEB1,
  input  logic [N-1:0] I1,
  output logic [N-1:0] O1,
  output logic         hit,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} tstate_e;

  tstate_e        state_q, state_d;
  logic [N-1:0]   o1_q, o1_d;
  logic           hit_q, hit_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           expired_q, expired_d;
  logic [N-1:0]   load_q, load_d;
  logic [2:0]     ctrl_q, ctrl_d;
  logic [N-1:0]   tcount_q, tcount_d;
  logic [N-1:0]   scratch_q, scratch_d;

  logic           sel, wr, rd, pop, push_req, push, ctrl_wr, expire;
  logic [3:0]     offset;
  logic [N-1:0]   status, ctrl_rd, rdata;

  always_comb begin
    // Address bit 0 is the MSB, so the window nibble A1[0:3] lives in A1[7:4] here.
    sel      = !CSB1 && (A1[7:4] == BASE[7:4]);
    offset   = A1[3:0];
    wr       = sel && !WEB1;
    rd       = sel && WEB1;

    status        = '0;
    status[0]     = (count_q == '0);
    status[1]     = (count_q == DEPTH_C);
    status[2]     = expired_q;
    status[3]     = (state_q == RUN);
    status[4]     = overflow_q;
    status[8 +: AW+1] = count_q;
    ctrl_rd       = '0;
    ctrl_rd[2:0]  = ctrl_q;

    case (offset)
      4'h0:    rdata = status;
      4'h2:    rdata = load_q;
      4'h3:    rdata = ctrl_rd;
      4'h4:    rdata = tcount_q;
      4'h5:    rdata = scratch_q;
      default: rdata = '0;
    endcase

    state_d    = state_q;
    o1_d       = o1_q;
    hit_d      = sel;
    mem_d      = mem_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    expired_d  = expired_q;
    load_d     = load_q;
    ctrl_d     = ctrl_q;
    tcount_d   = tcount_q;
    scratch_d  = scratch_q;
    expire     = 1'b0;

    if (rd) o1_d = rdata;

    pop      = (count_q != '0) && out_ready;
    push_req = wr && (offset == 4'h1);
    push     = push_req && ((count_q != DEPTH_C) || pop);
    if (push) begin
      mem_d[wptr_q] = I1[7:0];
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first, then set, so a fresh overflow in the same cycle survives the W1C.
    if (wr && (offset == 4'h0) && I1[4]) overflow_d = 1'b0;
    if (push_req && !push)                overflow_d = 1'b1;

    if (wr && (offset == 4'h2)) load_d    = I1;
    if (wr && (offset == 4'h5)) scratch_d = I1;

    ctrl_wr = wr && (offset == 4'h3);
    if (ctrl_wr) ctrl_d = I1[2:0];

    if (ctrl_wr && !I1[0]) begin
      state_d = IDLE;
    end else if (ctrl_wr && !ctrl_q[0]) begin
      state_d  = RUN;
      tcount_d = load_q;
    end else if (state_q == RUN) begin
      if (tcount_q != '0) begin
        tcount_d = tcount_q - 1'b1;
      end else begin
        expire = 1'b1;
        if (ctrl_d[1]) begin
          tcount_d = load_q;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
    end

    if (ctrl_wr && I1[N-1]) expired_d = 1'b0;
    if (expire)             expired_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      o1_q       <= '0;
      hit_q      <= 1'b0;
      mem_q      <= '{default: '0};
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      expired_q  <= 1'b0;
      load_q     <= '0;
      ctrl_q     <= '0;
      tcount_q   <= '0;
      scratch_q  <= '0;
    end else begin
      state_q    <= state_d;
      o1_q       <= o1_d;
      hit_q      <= hit_d;
      mem_q      <= mem_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      expired_q  <= expired_d;
      load_q     <= load_d;
      ctrl_q     <= ctrl_d;
      tcount_q   <= tcount_d;
      scratch_q  <= scratch_d;
    end
  end

  assign O1        = OEB1 ? '0 : o1_q;
  assign hit       = hit_q;
  assign out_data  = mem_q[rptr_q];
  assign out_valid = (count_q != '0);
  assign irq       = expired_q && ctrl_q[2];

endmodule

// File: tb/tb_mmio_responder.sv
// Directed scenarios for reset, decode, FIFO and timer, then randomized bus traffic
// checked against a queue-based model of the FIFO and register file.
module tb_mmio_responder;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  A1;
  logic        CSB1, WEB1, OEB1;
  logic [15:0] I1;
  logic [15:0] O1;
  logic        hit;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  mmio_responder #(.BASE(8'hF0), .FIFO_DEPTH(4), .N(16)) dut (
    .clock(clock), .reset(reset), .A1(A1), .CSB1(CSB1), .WEB1(WEB1), .OEB1(OEB1),
    .I1(I1), .O1(O1), .hit(hit), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    CSB1 = 1'b0; WEB1 = 1'b0; A1 = a; I1 = d;
    tick();
    CSB1 = 1'b1; WEB1 = 1'b1;
    $display("txn wr  %h <= %h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    CSB1 = 1'b0; WEB1 = 1'b1; A1 = a;
    tick();
    CSB1 = 1'b1;
    $display("txn rd  %h -> %h", a, O1);
    check(tag, {16'h0, O1}, {16'h0, exp});
  endtask

  // reference model state for the randomized phase
  logic [7:0]  q[$];
  logic        m_over;
  logic [15:0] m_load, m_scratch, m_o1, m_val, m_status;
  logic        m_hit;

  initial begin
    int kind, off, pre_n;
    logic [15:0] d;
    logic [7:0]  a;
    logic        csb, web, pop_m;

    reset = 1'b1; CSB1 = 1'b1; WEB1 = 1'b1; OEB1 = 1'b0; A1 = 8'h00; I1 = 16'h0; out_ready = 1'b0;
    tick();

    // reset asserted in the middle of a write to SCRATCH
    CSB1 = 1'b0; WEB1 = 1'b0; A1 = 8'hF5; I1 = 16'hBEEF;
    tick();
    #2 reset = 1'b0;
    #1;
    check("rst_o1",        {16'h0, O1},        32'h0);
    check("rst_hit",       {31'h0, hit},       32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data",  {24'h0, out_data},  32'h0);
    check("rst_irq",       {31'h0, irq},       32'h0);
    CSB1 = 1'b1; WEB1 = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    rd_chk("rst_scratch", 8'hF5, 16'h0000);
    check("rst_rd_hit", {31'h0, hit}, 32'h1);
    rd_chk("rst_status", 8'hF0, 16'h0001);

    // scratch and decode
    wr(8'hF5, 16'hA55A);
    rd_chk("scratch_rd", 8'hF5, 16'hA55A);
    check("scratch_hit", {31'h0, hit}, 32'h1);
    CSB1 = 1'b0; WEB1 = 1'b1; A1 = 8'h05;
    tick();
    CSB1 = 1'b1;
    $display("txn rd  05 (outside window)");
    check("outside_hit", {31'h0, hit}, 32'h0);
    check("outside_o1_hold", {16'h0, O1}, 32'h0000A55A);
    OEB1 = 1'b1;
    #1;
    check("oeb_forces_zero", {16'h0, O1}, 32'h0);
    OEB1 = 1'b0;

    // FIFO fill and overflow
    out_ready = 1'b0;
    check("fifo_empty_valid", {31'h0, out_valid}, 32'h0);
    wr(8'hF1, 16'h0011);
    check("fifo_valid_next_cycle", {31'h0, out_valid}, 32'h1);
    wr(8'hF1, 16'h0022);
    wr(8'hF1, 16'h0033);
    wr(8'hF1, 16'h0044);
    wr(8'hF1, 16'h0055);
    rd_chk("fifo_full_status", 8'hF0, 16'h0412);
    check("drain_0", {24'h0, out_data}, 32'h11);
    out_ready = 1'b1;
    tick(); check("drain_1", {24'h0, out_data}, 32'h22);
    tick(); check("drain_2", {24'h0, out_data}, 32'h33);
    tick(); check("drain_3", {24'h0, out_data}, 32'h44);
    tick(); check("drain_empty", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;
    wr(8'hF0, 16'h0010);
    rd_chk("overflow_w1c", 8'hF0, 16'h0001);

    // push into a full FIFO in the same cycle as a pop
    wr(8'hF1, 16'h00A1); wr(8'hF1, 16'h00A2); wr(8'hF1, 16'h00A3); wr(8'hF1, 16'h00A4);
    out_ready = 1'b1;
    wr(8'hF1, 16'h0066);
    out_ready = 1'b0;
    rd_chk("full_pushpop_status", 8'hF0, 16'h0402);
    out_ready = 1'b1;
    check("pp_0", {24'h0, out_data}, 32'hA2);
    tick(); check("pp_1", {24'h0, out_data}, 32'hA3);
    tick(); check("pp_2", {24'h0, out_data}, 32'hA4);
    tick(); check("pp_3", {24'h0, out_data}, 32'h66);
    tick(); check("pp_empty", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // one-shot timer
    wr(8'hF2, 16'h0003);
    wr(8'hF3, 16'h0005);
    rd_chk("os_count3", 8'hF4, 16'h0003);
    rd_chk("os_count2", 8'hF4, 16'h0002);
    rd_chk("os_count1", 8'hF4, 16'h0001);
    check("os_irq_not_yet", {31'h0, irq}, 32'h0);
    rd_chk("os_count0", 8'hF4, 16'h0000);
    check("os_irq_rise", {31'h0, irq}, 32'h1);
    rd_chk("os_ctrl_enable_cleared", 8'hF3, 16'h0004);
    rd_chk("os_status_expired", 8'hF0, 16'h0005);
    wr(8'hF3, 16'h8004);
    check("os_irq_cleared", {31'h0, irq}, 32'h0);
    rd_chk("os_status_cleared", 8'hF0, 16'h0001);

    // auto-reload timer
    wr(8'hF2, 16'h0001);
    wr(8'hF3, 16'h0003);
    rd_chk("ar_count_a", 8'hF4, 16'h0001);
    rd_chk("ar_count_b", 8'hF4, 16'h0000);
    rd_chk("ar_count_c", 8'hF4, 16'h0001);
    rd_chk("ar_count_d", 8'hF4, 16'h0000);
    rd_chk("ar_status_running", 8'hF0, 16'h000D);
    check("ar_irq_masked", {31'h0, irq}, 32'h0);
    // LOAD=0 expires every cycle, so a clear in the same write must lose
    wr(8'hF2, 16'h0000);
    tick(); tick();
    wr(8'hF3, 16'h8003);
    rd_chk("clear_vs_expire", 8'hF0, 16'h000D);
    wr(8'hF3, 16'h8000);
    rd_chk("timer_stopped", 8'hF0, 16'h0001);

    // randomized traffic against the behavioural model
    reset = 1'b0; tick(); reset = 1'b1; tick();
    q.delete(); m_over = 1'b0; m_load = '0; m_scratch = '0; m_o1 = '0;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 7);
      off  = $urandom_range(0, 15);
      d    = 16'($urandom);
      csb  = 1'b0; web = 1'b0;
      case (kind)
        0: begin web = 1'b1; a = {4'hF, 4'(off)}; end
        1: a = 8'hF1;
        2: a = 8'hF5;
        3: a = 8'hF2;
        4: a = 8'hF0;
        5: begin a = {4'($urandom_range(0, 14)), 4'(off)}; web = 1'($urandom); end
        6: begin csb = 1'b1; a = {4'hF, 4'(off)}; web = 1'($urandom); end
        default: a = {4'hF, 4'($urandom_range(6, 15))};
      endcase

      pre_n    = q.size();
      pop_m    = (pre_n != 0) && out_ready;
      m_status = {3'b0, 5'(pre_n), 3'b0, m_over, 2'b00, (pre_n == 4), (pre_n == 0)};
      case (a[3:0])
        4'h0: m_val = m_status;
        4'h2: m_val = m_load;
        4'h5: m_val = m_scratch;
        default: m_val = 16'h0;
      endcase
      m_hit = !csb && (a[7:4] == 4'hF);
      if (m_hit && web) m_o1 = m_val;
      if (pop_m) void'(q.pop_front());
      if (m_hit && !web) begin
        if (a[3:0] == 4'h0 && d[4]) m_over = 1'b0;
        if (a[3:0] == 4'h1) begin
          if (pre_n < 4 || pop_m) q.push_back(d[7:0]);
          else m_over = 1'b1;
        end
        if (a[3:0] == 4'h2) m_load = d;
        if (a[3:0] == 4'h5) m_scratch = d;
      end

      CSB1 = csb; WEB1 = web; A1 = a; I1 = d;
      tick();
      OEB1 = ($urandom_range(0, 7) == 0);
      #1;
      $display("txn rnd %0d csb=%b web=%b a=%h d=%h o1=%h", i, csb, web, a, d, O1);
      check("rnd_o1", {16'h0, O1}, {16'h0, (OEB1 ? 16'h0 : m_o1)});
      check("rnd_hit", {31'h0, hit}, {31'h0, m_hit});
      check("rnd_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
      if (q.size() != 0) check("rnd_head", {24'h0, out_data}, {24'h0, q[0]});
      OEB1 = 1'b0;
      out_ready = 1'($urandom);
    end
    CSB1 = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Bus-side responder for the processor's SRAM-style memory port; it is the target end of the same A1/CSB1/WEB1/OEB1/I1/O1 protocol the core drives into SRAM256x16.
- Claims a 16-word address window and exposes memory-mapped I/O:
  - a transmit FIFO drained by an external ready/valid sink;
  - a down-counting timer with interrupt;
  - a scratch register.
- Sits beside SRAM256x16 on the address bus. The top level steers the data bus from the `hit` output.

Parameters:
- BASE, 8'hF0: window base; A1[0:3] must equal BASE[0:3]; offset = A1[4:7].
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, 2..16.
- N, 16: data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- A1  in  8  word address, bit 0 = MSB.
- CSB1  in  1  chip select, active low.
- WEB1  in  1  write enable, active low; 1 = read.
- OEB1  in  1  output enable, active low.
- I1  in  N  write data.
- O1  out  N  read data.
- hit  out  1  registered: last sampled access fell in window.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts head this cycle.
- irq  out  1  timer_expired AND ctrl.irq_en.

Behaviour:
- Access sampling:
  - An access is sampled on the rising clock edge when CSB1=0 and A1[0:3]==BASE[0:3].
  - Outside the window, or with CSB1=1: no state change, hit<=0, O1 holds.
- Reads (WEB1=1): O1 <= register[offset] at that edge, so data is valid the cycle after the address, matching the SRAM timing. hit<=1.
- Writes (WEB1=0): the register updates at that edge. O1 holds. hit<=1.
- OEB1=1 forces O1 to all zeros combinationally. There is no tristate.
- Register map:
  - 0x0 STATUS, RO except W1C bit 4.
    - [0] fifo_empty
    - [1] fifo_full
    - [2] timer_expired
    - [3] timer_running
    - [4] overflow, sticky
    - [8:12] fifo_count
    - all other bits 0
  - 0x1 TXDATA, WO.
    - A write pushes I1[8:15] (low byte).
    - If full and no same-cycle pop: the data is dropped and overflow is set.
    - Reads return 0.
  - 0x2 TIMER_LOAD, RW: 16-bit reload value.
  - 0x3 TIMER_CTRL, RW.
    - [0] enable, [1] auto_reload, [2] irq_en.
    - Writing bit 15 = 1 clears timer_expired. Bit 15 reads 0.
  - 0x4 TIMER_COUNT, RO: current count.
  - 0x5 SCRATCH, RW.
  - 0x6-0xF: read 0; writes ignored.
- FIFO:
  - Circular buffer with read/write pointers and a count. out_data = mem[rptr]. out_valid = (count != 0).
  - Pop happens when out_valid & out_ready.
  - Push happens on a TXDATA write when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while empty: out_valid rises the next cycle. There is no bypass.
- Timer FSM, states IDLE and RUN:
  - IDLE -> RUN on a write to TIMER_CTRL with enable 0->1; count <= TIMER_LOAD the same edge.
  - In RUN, each cycle with count != 0: count <= count-1.
  - In RUN with count==0:
    - timer_expired <= 1;
    - if auto_reload: count <= TIMER_LOAD, stay in RUN;
    - else: enable <= 0, go to IDLE, count holds at 0.
  - A write clearing enable forces IDLE with count frozen.
  - TIMER_LOAD=0 with auto_reload set expires every cycle.
  - Clear and expire in the same cycle: expire wins, so timer_expired stays 1.
  - W1C overflow and a new overflow in the same cycle: the set wins.
- Reset (reset=0, asynchronous, any cycle including mid-access):
  - O1=0, hit=0, out_valid=0, out_data=0, irq=0.
  - FIFO pointers and count = 0; all registers = 0; timer in IDLE; overflow=0; timer_expired=0.
  - Release is synchronous to the next rising edge.
- Arithmetic: the counter is unsigned N-bit; there is no wrap below 0.

Test Plan:
- Reset mid-write:
  - Stimulus: assert reset while CSB1=0/WEB1=0 to 0xF5 with I1=16'hBEEF.
  - Response: on release, a read of 0xF5 gives O1=0; STATUS reads 16'h0001.
- Scratch / decode:
  - Stimulus: write 0xF5=16'hA55A; read 0xF5; read 0x05 (outside window).
  - Response: O1=16'hA55A one cycle after the read with hit=1; the 0x05 access gives hit=0 and O1 holds A55A.
- FIFO fill/overflow:
  - Stimulus: out_ready=0; write TXDATA with 0x11, 0x22, 0x33, 0x44, 0x55.
  - Response: STATUS[8:12]=4, full=1, overflow=1.
  - Then out_ready=1: out_data sequence is 11, 22, 33, 44 on consecutive cycles, then out_valid=0.
- Full push+pop:
  - Stimulus: FIFO full with out_ready=1; write TXDATA 0x66 in the same cycle as a pop.
  - Response: count stays 4, overflow stays 0, and 0x66 emerges last.
- Timer one-shot:
  - Stimulus: LOAD=3; CTRL=16'h0005.
  - Response: COUNT reads 3, 2, 1, 0 on successive cycles; timer_expired and irq rise the cycle after count=0; enable reads 0.
  - Then writing CTRL=16'h8004 clears irq.
- Timer auto-reload:
  - Stimulus: LOAD=1; CTRL=16'h0003.
  - Response: count cycles 1, 0, 1, 0; timer_expired stays 1; timer_running=1 throughout.
